// File: rtl/centroid_stream_if.sv
// ============================================================================
//  Module      : centroid_stream_if
//  Description : Bus bundle for centroid_stream. Carries the binarised video
//                input (de/hsync/vsync/mask) and the per-frame result
//                (x/y/area/valid/found/dropped).
//                Optional bounding-box outputs exist when CENTROID_BBOX_EN
//                is defined.
//  Modports    : master - video source / result consumer
//                slave  - centroid unit (video sink / result producer)
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface centroid_stream_if #(
    parameter int COORD_W = 11,
    parameter int A_W     = 13
);
    // video input
    logic               de;
    logic               hsync;
    logic               vsync;
    logic               mask;
    // frame result
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic [A_W-1:0]     area;
    logic               valid;
    logic               found;
    logic               dropped;
`ifdef CENTROID_BBOX_EN
    logic [COORD_W-1:0] x_min;
    logic [COORD_W-1:0] x_max;
    logic [COORD_W-1:0] y_min;
    logic [COORD_W-1:0] y_max;
`endif

    modport master (
        output de, hsync, vsync, mask,
        input  x, y, area, valid, found, dropped
`ifdef CENTROID_BBOX_EN
        , input x_min, x_max, y_min, y_max
`endif
    );

    modport slave (
        input  de, hsync, vsync, mask,
        output x, y, area, valid, found, dropped
`ifdef CENTROID_BBOX_EN
        , output x_min, x_max, y_min, y_max
`endif
    );
endinterface

`default_nettype wire

// File: rtl/centroid_stream.sv
// ============================================================================
//  Module      : centroid_stream
//  Description : Streaming binary-mask centroid unit. Accumulates area (m00)
//                and first moments (m10, m01) over a frame, snapshots them at
//                end of frame (vsync rising edge) and divides with two
//                parallel restoring dividers (one quotient bit per cycle).
//                A one-cycle valid strobe presents x/y/area/found/dropped.
//  Ports       : clk  - pixel clock (rising edge)
//                rst  - synchronous active-high reset
//                ce   - clock enable, ce=0 freezes all state
//                bus  - centroid_stream_if.slave (video in, result out)
//  Option      : CENTROID_BBOX_EN - adds x_min/x_max/y_min/y_max tracking
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module centroid_stream #(
    parameter int IMG_W    = 64,
    parameter int IMG_H    = 64,
    parameter int COORD_W  = 11,
    parameter int MIN_AREA = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ce,
    centroid_stream_if.slave   bus
);
    localparam int A_W  = $clog2(IMG_W * IMG_H + 1);
    localparam int M_W  = A_W + COORD_W;
    localparam int IT_W = $clog2(COORD_W + 1);

    localparam logic [COORD_W-1:0] c_x_last    = COORD_W'(IMG_W - 1);
    localparam logic [COORD_W-1:0] c_y_last    = COORD_W'(IMG_H - 1);
    localparam logic [IT_W-1:0]    c_last_iter = IT_W'(COORD_W - 1);
    localparam logic [A_W-1:0]     c_min_area  = A_W'(MIN_AREA);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CHECK = 2'd1,
        S_DIV   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic               r_prev_vsync;
    logic [COORD_W-1:0] r_x_pos;
    logic [COORD_W-1:0] r_y_pos;
    logic [A_W-1:0]     r_m00;
    logic [M_W-1:0]     r_m10;
    logic [M_W-1:0]     r_m01;
    logic [A_W-1:0]     r_s00;
    logic [M_W-1:0]     r_s10;
    logic [M_W-1:0]     r_s01;
    logic [A_W-1:0]     r_rem_x;
    logic [A_W-1:0]     r_rem_y;
    logic [COORD_W-1:0] r_q_x;
    logic [COORD_W-1:0] r_q_y;
    logic [IT_W-1:0]    r_iter;

    logic               w_eof;
    logic               w_busy;
    logic               w_pix;
    logic               w_small;
    logic               w_last;
    logic               w_unused_hsync;

    assign w_eof          = bus.vsync & ~r_prev_vsync;
    assign w_busy         = (r_state != S_IDLE);
    // vsync high holds the scan in reset, so no pixel is counted then
    assign w_pix          = bus.de & ~bus.vsync & bus.mask;
    assign w_small        = (r_s00 < c_min_area);
    assign w_last         = (r_iter == c_last_iter);
    assign w_unused_hsync = bus.hsync;
    assign bus.valid      = (r_state == S_DONE);

    // ------------------------------------------------------------------
    // Restoring divider step. The low dividend bits sit in r_q_* and are
    // shifted out MSB first while quotient bits are shifted in. The
    // partial remainder is always < divisor, so the trial value fits in
    // A_W+1 bits and the difference fits in A_W bits.
    // ------------------------------------------------------------------
    logic [A_W:0]       w_trial_x, w_trial_y;
    logic               w_ge_x, w_ge_y;
    logic [A_W-1:0]     w_rem_x_nxt, w_rem_y_nxt;
    logic [COORD_W-1:0] w_q_x_nxt, w_q_y_nxt;

    assign w_trial_x   = {r_rem_x, r_q_x[COORD_W-1]};
    assign w_trial_y   = {r_rem_y, r_q_y[COORD_W-1]};
    assign w_ge_x      = (w_trial_x >= {1'b0, r_s00});
    assign w_ge_y      = (w_trial_y >= {1'b0, r_s00});
    assign w_rem_x_nxt = w_ge_x ? (w_trial_x[A_W-1:0] - r_s00) : w_trial_x[A_W-1:0];
    assign w_rem_y_nxt = w_ge_y ? (w_trial_y[A_W-1:0] - r_s00) : w_trial_y[A_W-1:0];
    assign w_q_x_nxt   = {r_q_x[COORD_W-2:0], w_ge_x};
    assign w_q_y_nxt   = {r_q_y[COORD_W-2:0], w_ge_y};

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else if (ce) begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_eof) w_state_nxt = S_CHECK;
            S_CHECK: w_state_nxt = w_small ? S_DONE : S_DIV;
            S_DIV:   if (w_last) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Scan, accumulation, snapshot, division and result registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_prev_vsync <= 1'b0;
            r_x_pos      <= '0;
            r_y_pos      <= '0;
            r_m00        <= '0;
            r_m10        <= '0;
            r_m01        <= '0;
            r_s00        <= '0;
            r_s10        <= '0;
            r_s01        <= '0;
            r_rem_x      <= '0;
            r_rem_y      <= '0;
            r_q_x        <= '0;
            r_q_y        <= '0;
            r_iter       <= '0;
            bus.x        <= '0;
            bus.y        <= '0;
            bus.area     <= '0;
            bus.found    <= 1'b0;
            bus.dropped  <= 1'b0;
        end else if (ce) begin
            r_prev_vsync <= bus.vsync;

            if (bus.vsync) begin
                r_x_pos <= '0;
                r_y_pos <= '0;
            end else if (bus.de) begin
                if (r_x_pos == c_x_last) begin
                    r_x_pos <= '0;
                    r_y_pos <= (r_y_pos == c_y_last) ? '0 : r_y_pos + COORD_W'(1);
                end else begin
                    r_x_pos <= r_x_pos + COORD_W'(1);
                end
            end

            if (w_eof) begin
                r_m00 <= '0;
                r_m10 <= '0;
                r_m01 <= '0;
            end else if (w_pix) begin
                r_m00 <= r_m00 + A_W'(1);
                r_m10 <= r_m10 + M_W'(r_x_pos);
                r_m01 <= r_m01 + M_W'(r_y_pos);
            end

            if (w_eof && !w_busy) begin
                r_s00 <= r_m00;
                r_s10 <= r_m10;
                r_s01 <= r_m01;
            end

            // a new drop takes priority over the post-strobe clear
            if (w_eof && w_busy) begin
                bus.dropped <= 1'b1;
            end else if (r_state == S_DONE) begin
                bus.dropped <= 1'b0;
            end

            if (r_state == S_CHECK) begin
                if (w_small) begin
                    bus.found <= 1'b0;
                    bus.area  <= r_s00;
                end else begin
                    r_rem_x <= r_s10[M_W-1:COORD_W];
                    r_rem_y <= r_s01[M_W-1:COORD_W];
                    r_q_x   <= r_s10[COORD_W-1:0];
                    r_q_y   <= r_s01[COORD_W-1:0];
                    r_iter  <= '0;
                end
            end

            if (r_state == S_DIV) begin
                r_rem_x <= w_rem_x_nxt;
                r_rem_y <= w_rem_y_nxt;
                r_q_x   <= w_q_x_nxt;
                r_q_y   <= w_q_y_nxt;
                r_iter  <= r_iter + IT_W'(1);
                if (w_last) begin
                    bus.x     <= w_q_x_nxt;
                    bus.y     <= w_q_y_nxt;
                    bus.area  <= r_s00;
                    bus.found <= 1'b1;
                end
            end
        end
    end

`ifdef CENTROID_BBOX_EN
    // ------------------------------------------------------------------
    // Bounding box over mask pixels, following the moment pipeline
    // ------------------------------------------------------------------
    logic [COORD_W-1:0] r_bx_min, r_bx_max, r_by_min, r_by_max;
    logic [COORD_W-1:0] r_sx_min, r_sx_max, r_sy_min, r_sy_max;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_bx_min  <= '1;
            r_bx_max  <= '0;
            r_by_min  <= '1;
            r_by_max  <= '0;
            r_sx_min  <= '1;
            r_sx_max  <= '0;
            r_sy_min  <= '1;
            r_sy_max  <= '0;
            bus.x_min <= '1;
            bus.x_max <= '0;
            bus.y_min <= '1;
            bus.y_max <= '0;
        end else if (ce) begin
            if (w_eof) begin
                r_bx_min <= '1;
                r_bx_max <= '0;
                r_by_min <= '1;
                r_by_max <= '0;
            end else if (w_pix) begin
                if (r_x_pos < r_bx_min) r_bx_min <= r_x_pos;
                if (r_x_pos > r_bx_max) r_bx_max <= r_x_pos;
                if (r_y_pos < r_by_min) r_by_min <= r_y_pos;
                if (r_y_pos > r_by_max) r_by_max <= r_y_pos;
            end

            if (w_eof && !w_busy) begin
                r_sx_min <= r_bx_min;
                r_sx_max <= r_bx_max;
                r_sy_min <= r_by_min;
                r_sy_max <= r_by_max;
            end

            // frames below MIN_AREA report the empty box even if some
            // pixels were seen
            if (r_state == S_CHECK && w_small) begin
                bus.x_min <= '1;
                bus.x_max <= '0;
                bus.y_min <= '1;
                bus.y_max <= '0;
            end else if (r_state == S_DIV && w_last) begin
                bus.x_min <= r_sx_min;
                bus.x_max <= r_sx_max;
                bus.y_min <= r_sy_min;
                bus.y_max <= r_sy_max;
            end
        end
    end
`endif

endmodule

`default_nettype wire
